// File: rtl/mem_resp_queue_if.sv
// Request/response/retire bundle between the EXE data-bus port, the memory
// response channel and the WB stage for the in-order response queue.
interface mem_resp_queue_if #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32
);
  localparam int OFF_W = $clog2(DATA_W / 8);

  logic              req_valid;
  logic              req_ready;
  logic              req_is_load;
  logic [1:0]        req_size;
  logic              req_sign;
  logic [OFF_W-1:0]  req_offset;
  logic [4:0]        req_rd;
  logic [PC_W-1:0]   req_pc;

  logic              data_ok;
  logic [DATA_W-1:0] rdata;

  logic              out_valid;
  logic              out_ready;
  logic              out_is_load;
  logic [4:0]        out_rd;
  logic [DATA_W-1:0] out_wdata;
  logic [PC_W-1:0]   out_pc;

  modport master (
    output req_valid, req_is_load, req_size, req_sign, req_offset, req_rd, req_pc,
    input  req_ready,
    output data_ok, rdata,
    input  out_valid, out_is_load, out_rd, out_wdata, out_pc,
    output out_ready
  );

  modport slave (
    input  req_valid, req_is_load, req_size, req_sign, req_offset, req_rd, req_pc,
    output req_ready,
    input  data_ok, rdata,
    output out_valid, out_is_load, out_rd, out_wdata, out_pc,
    input  out_ready
  );
endinterface

// File: rtl/mem_resp_queue.sv
// In-order tracker for up to DEPTH outstanding loads/stores: aligns and extends
// returned beats, retires them to WB in issue order, and drops beats owed after a flush.
module mem_resp_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int PC_W   = 32
) (
  input  logic              clk,
  input  logic              resetn,
  mem_resp_queue_if.slave   bus,
  input  logic              flush,
  output logic              resp_err
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int OFF_W = $clog2(DATA_W / 8);

  logic [DEPTH-1:0]  ent_is_load;
  logic [DEPTH-1:0]  ent_sign;
  logic [DEPTH-1:0]  done;
  logic [1:0]        ent_size   [DEPTH];
  logic [OFF_W-1:0]  ent_offset [DEPTH];
  logic [4:0]        ent_rd     [DEPTH];
  logic [PC_W-1:0]   ent_pc     [DEPTH];
  logic [DATA_W-1:0] ent_data   [DEPTH];

  logic [PTR_W-1:0]  wr_ptr, rsp_ptr, rd_ptr;
  logic [CNT_W-1:0]  count, pend, drop_cnt;
  logic [CNT_W:0]    occupancy;
  logic              issue, drop_beat, take_beat, stray_beat, head_valid, retire;

  function automatic logic [DATA_W-1:0] extract(
    input logic [DATA_W-1:0] word,
    input logic [1:0]        size,
    input logic              sign,
    input logic [OFF_W-1:0]  off
  );
    logic [OFF_W-1:0]  lane;
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] mask;
    logic              msb;
    lane = off;
    mask = '1;
    case (size)
      2'b00:   mask = DATA_W'(8'hFF);
      2'b01: begin
        lane[0] = 1'b0;
        mask    = DATA_W'(16'hFFFF);
      end
      2'b10: begin
        lane = lane & ~OFF_W'(3);
        mask = DATA_W'(32'hFFFF_FFFF);
      end
      default: lane = '0;
    endcase
    shifted = word >> {lane, 3'b000};
    case (size)
      2'b00:   msb = shifted[7];
      2'b01:   msb = shifted[15];
      2'b10:   msb = shifted[31];
      default: msb = 1'b0;
    endcase
    return (shifted & mask) | ((sign & msb) ? ~mask : '0);
  endfunction

  // Beats still owed to flushed accesses take precedence over live ones.
  assign occupancy  = {1'b0, count} + {1'b0, drop_cnt};
  assign issue      = bus.req_valid & bus.req_ready;
  assign drop_beat  = bus.data_ok & (drop_cnt != '0);
  assign take_beat  = bus.data_ok & (drop_cnt == '0) & (pend != '0);
  assign stray_beat = bus.data_ok & (drop_cnt == '0) & (pend == '0);
  assign head_valid = (count != '0) & done[rd_ptr] & ~flush;
  assign retire     = head_valid & bus.out_ready;

  assign bus.req_ready   = occupancy < (CNT_W + 1)'(DEPTH);
  assign bus.out_valid   = head_valid;
  assign bus.out_is_load = ent_is_load[rd_ptr];
  assign bus.out_rd      = ent_is_load[rd_ptr] ? ent_rd[rd_ptr] : 5'd0;
  assign bus.out_wdata   = ent_is_load[rd_ptr] ? ent_data[rd_ptr] : '0;
  assign bus.out_pc      = ent_pc[rd_ptr];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr   <= '0;
      rsp_ptr  <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      pend     <= '0;
      drop_cnt <= '0;
      done     <= '0;
      resp_err <= 1'b0;
    end else begin
      if (stray_beat)
        resp_err <= 1'b1;
      if (flush) begin
        // Everything not yet returned, including a same-cycle issue, is owed as a drop.
        drop_cnt <= drop_cnt + pend + CNT_W'(issue) - CNT_W'(take_beat) - CNT_W'(drop_beat);
        wr_ptr   <= '0;
        rsp_ptr  <= '0;
        rd_ptr   <= '0;
        count    <= '0;
        pend     <= '0;
        done     <= '0;
      end else begin
        if (issue) begin
          wr_ptr         <= wr_ptr + 1'b1;
          done[wr_ptr]   <= 1'b0;
        end
        if (take_beat) begin
          rsp_ptr        <= rsp_ptr + 1'b1;
          done[rsp_ptr]  <= 1'b1;
        end
        if (retire)
          rd_ptr <= rd_ptr + 1'b1;
        count    <= count + CNT_W'(issue) - CNT_W'(retire);
        pend     <= pend + CNT_W'(issue) - CNT_W'(take_beat);
        drop_cnt <= drop_cnt - CNT_W'(drop_beat);
      end
    end
  end

  // Payload storage needs no reset: done bits and counts gate every use of it.
  always_ff @(posedge clk) begin
    if (issue) begin
      ent_is_load[wr_ptr] <= bus.req_is_load;
      ent_sign[wr_ptr]    <= bus.req_sign;
      ent_size[wr_ptr]    <= bus.req_size;
      ent_offset[wr_ptr]  <= bus.req_offset;
      ent_rd[wr_ptr]      <= bus.req_rd;
      ent_pc[wr_ptr]      <= bus.req_pc;
    end
    if (take_beat)
      ent_data[rsp_ptr] <= extract(bus.rdata, ent_size[rsp_ptr], ent_sign[rsp_ptr],
                                   ent_offset[rsp_ptr]);
  end
endmodule

// File: tb/tb_mem_resp_queue.sv
// Directed bench for mem_resp_queue (DEPTH=4, DATA_W=32): extraction table plus
// hand-written full, flush, backpressure and error/reset sequences.
module tb_mem_resp_queue;
  logic clk;
  logic resetn;
  logic flush;
  logic resp_err;
  int   tests_run;
  int   tests_failed;

  mem_resp_queue_if #(.DATA_W(32), .PC_W(32)) bus ();

  mem_resp_queue #(.DEPTH(4), .DATA_W(32), .PC_W(32)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .bus      (bus),
    .flush    (flush),
    .resp_err (resp_err)
  );

  typedef struct {
    logic [1:0]  size;
    logic        sign;
    logic [1:0]  off;
    logic [31:0] rdata;
    logic [31:0] expected;
  } ext_vec_t;

  ext_vec_t vecs [10];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic issue_access(input logic is_load, input logic [1:0] size, input logic sign,
                              input logic [1:0] off, input logic [4:0] rd, input logic [31:0] pc);
    bus.req_valid   = 1'b1;
    bus.req_is_load = is_load;
    bus.req_size    = size;
    bus.req_sign    = sign;
    bus.req_offset  = off;
    bus.req_rd      = rd;
    bus.req_pc      = pc;
    tick();
    bus.req_valid   = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] data);
    bus.data_ok = 1'b1;
    bus.rdata   = data;
    tick();
    bus.data_ok = 1'b0;
  endtask

  task automatic retire_head();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic apply_stimulus(input int idx);
    issue_access(1'b1, vecs[idx].size, vecs[idx].sign, vecs[idx].off, 5'(idx + 1), 32'h1c00_0100);
    send_beat(vecs[idx].rdata);
    check_output($sformatf("extract[%0d].valid", idx), 64'(bus.out_valid), 64'd1);
    check_output($sformatf("extract[%0d].wdata", idx), 64'(bus.out_wdata), 64'(vecs[idx].expected));
    check_output($sformatf("extract[%0d].rd", idx), 64'(bus.out_rd), 64'(idx + 1));
    retire_head();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    tests_run     = 0;
    tests_failed  = 0;
    resetn        = 1'b0;
    flush         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_is_load = 1'b0;
    bus.req_size  = 2'b10;
    bus.req_sign  = 1'b0;
    bus.req_offset = 2'd0;
    bus.req_rd    = 5'd0;
    bus.req_pc    = 32'd0;
    bus.data_ok   = 1'b0;
    bus.rdata     = 32'd0;
    bus.out_ready = 1'b0;

    vecs[0] = '{2'b00, 1'b1, 2'd0, 32'h1234_80FF, 32'hFFFF_FFFF};
    vecs[1] = '{2'b00, 1'b0, 2'd1, 32'h1234_80FF, 32'h0000_0080};
    vecs[2] = '{2'b01, 1'b1, 2'd2, 32'h1234_80FF, 32'h0000_1234};
    vecs[3] = '{2'b01, 1'b1, 2'd0, 32'h1234_80FF, 32'hFFFF_80FF};
    vecs[4] = '{2'b01, 1'b0, 2'd0, 32'h1234_80FF, 32'h0000_80FF};
    vecs[5] = '{2'b00, 1'b1, 2'd1, 32'h1234_80FF, 32'hFFFF_FF80};
    vecs[6] = '{2'b00, 1'b1, 2'd3, 32'h1234_80FF, 32'h0000_0012};
    vecs[7] = '{2'b10, 1'b1, 2'd0, 32'h1234_80FF, 32'h1234_80FF};
    vecs[8] = '{2'b01, 1'b1, 2'd2, 32'h8000_7F00, 32'hFFFF_8000};
    vecs[9] = '{2'b00, 1'b1, 2'd1, 32'h8000_7F00, 32'h0000_007F};

    #12;
    check_output("reset.out_valid", 64'(bus.out_valid), 64'd0);
    check_output("reset.req_ready", 64'(bus.req_ready), 64'd1);
    check_output("reset.resp_err", 64'(resp_err), 64'd0);
    resetn = 1'b1;
    tick();

    // Single LW with a three-cycle response latency
    issue_access(1'b1, 2'b10, 1'b0, 2'd0, 5'd5, 32'h1c00_0000);
    tick();
    tick();
    check_output("single.not_yet_valid", 64'(bus.out_valid), 64'd0);
    send_beat(32'h8000_00F0);
    check_output("single.valid", 64'(bus.out_valid), 64'd1);
    check_output("single.rd", 64'(bus.out_rd), 64'd5);
    check_output("single.wdata", 64'(bus.out_wdata), 64'h8000_00F0);
    check_output("single.pc", 64'(bus.out_pc), 64'h1c00_0000);
    check_output("single.req_ready", 64'(bus.req_ready), 64'd1);
    retire_head();
    check_output("single.retired", 64'(bus.out_valid), 64'd0);

    for (int i = 0; i < 10; i++)
      apply_stimulus(i);

    // Fill all four slots, try a fifth, then drain in order
    for (int i = 0; i < 4; i++)
      issue_access(1'b1, 2'b10, 1'b0, 2'd0, 5'(i + 1), 32'h2000_0000 + 32'(4 * i));
    check_output("full.req_ready", 64'(bus.req_ready), 64'd0);
    issue_access(1'b1, 2'b10, 1'b0, 2'd0, 5'd9, 32'h2000_0040);
    for (int i = 0; i < 4; i++)
      send_beat(32'hA + 32'(i));
    check_output("full.head_valid", 64'(bus.out_valid), 64'd1);
    check_output("full.still_full", 64'(bus.req_ready), 64'd0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_output($sformatf("full.wdata[%0d]", i), 64'(bus.out_wdata), 64'hA + 64'(i));
      check_output($sformatf("full.rd[%0d]", i), 64'(bus.out_rd), 64'(i + 1));
      tick();
      if (i == 0)
        check_output("full.ready_after_retire", 64'(bus.req_ready), 64'd1);
    end
    bus.out_ready = 1'b0;
    check_output("full.fifth_ignored", 64'(bus.out_valid), 64'd0);

    // Flush with two beats outstanding and a same-cycle issue: three beats owed
    for (int i = 0; i < 3; i++)
      issue_access(1'b1, 2'b10, 1'b0, 2'd0, 5'(i + 1), 32'h3000_0000);
    send_beat(32'h11);
    check_output("flush.pre_valid", 64'(bus.out_valid), 64'd1);
    flush = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_rd = 5'd4;
    bus.out_ready = 1'b1;
    #1;
    check_output("flush.valid_masked", 64'(bus.out_valid), 64'd0);
    tick();
    flush = 1'b0;
    bus.req_valid = 1'b0;
    bus.out_ready = 1'b0;
    check_output("flush.after_valid", 64'(bus.out_valid), 64'd0);
    check_output("flush.after_ready", 64'(bus.req_ready), 64'd1);
    for (int i = 0; i < 3; i++) begin
      send_beat(32'hEE);
      check_output($sformatf("flush.drop_valid[%0d]", i), 64'(bus.out_valid), 64'd0);
      check_output($sformatf("flush.drop_err[%0d]", i), 64'(resp_err), 64'd0);
    end
    issue_access(1'b1, 2'b10, 1'b0, 2'd0, 5'd6, 32'h3000_0010);
    send_beat(32'h55);
    check_output("flush.new_valid", 64'(bus.out_valid), 64'd1);
    check_output("flush.new_wdata", 64'(bus.out_wdata), 64'h55);
    check_output("flush.new_err", 64'(resp_err), 64'd0);
    retire_head();

    // Store ahead of a load, held by WB backpressure
    issue_access(1'b0, 2'b10, 1'b0, 2'd0, 5'd7, 32'h0000_0100);
    issue_access(1'b1, 2'b10, 1'b0, 2'd0, 5'd8, 32'h0000_0104);
    send_beat(32'hDEAD_BEEF);
    send_beat(32'h77);
    for (int i = 0; i < 5; i++) begin
      check_output($sformatf("store.valid[%0d]", i), 64'(bus.out_valid), 64'd1);
      check_output($sformatf("store.is_load[%0d]", i), 64'(bus.out_is_load), 64'd0);
      check_output($sformatf("store.rd[%0d]", i), 64'(bus.out_rd), 64'd0);
      check_output($sformatf("store.wdata[%0d]", i), 64'(bus.out_wdata), 64'd0);
      check_output($sformatf("store.pc[%0d]", i), 64'(bus.out_pc), 64'h100);
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    check_output("store.load_valid", 64'(bus.out_valid), 64'd1);
    check_output("store.load_is_load", 64'(bus.out_is_load), 64'd1);
    check_output("store.load_rd", 64'(bus.out_rd), 64'd8);
    check_output("store.load_wdata", 64'(bus.out_wdata), 64'h77);
    check_output("store.load_pc", 64'(bus.out_pc), 64'h104);
    tick();
    bus.out_ready = 1'b0;
    check_output("store.drained", 64'(bus.out_valid), 64'd0);

    // Stray beat then asynchronous reset while the queue is full
    send_beat(32'h1);
    check_output("err.sticky_set", 64'(resp_err), 64'd1);
    for (int i = 0; i < 4; i++)
      issue_access(1'b1, 2'b10, 1'b0, 2'd0, 5'(i + 10), 32'h4000_0000);
    send_beat(32'h99);
    check_output("err.still_set", 64'(resp_err), 64'd1);
    check_output("err.pre_valid", 64'(bus.out_valid), 64'd1);
    check_output("err.pre_ready", 64'(bus.req_ready), 64'd0);
    #2;
    resetn = 1'b0;
    #1;
    check_output("areset.resp_err", 64'(resp_err), 64'd0);
    check_output("areset.out_valid", 64'(bus.out_valid), 64'd0);
    check_output("areset.req_ready", 64'(bus.req_ready), 64'd1);
    #3;
    resetn = 1'b1;
    tick();
    check_output("areset.stays_empty", 64'(bus.out_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/mem_resp_queue.md
Name: mem_resp_queue

Overview:
Multi-outstanding load/store response tracker that sits between the EXE-stage data-bus request and the WB stage. It replaces the single-access blocking wait (ready_go held until data_ok) with an in-order queue of up to DEPTH outstanding accesses. Each returned beat is aligned and sign-extended for byte, half, word and (for 64-bit buses) doubleword loads. On an exception, ertn or refetch flush, responses still owed by the bus are silently discarded.

Parameters:
DEPTH, 4, max accesses in flight (issued but not retired or dropped); power of 2, range 2..16
DATA_W, 32, data bus width; 32 or 64
PC_W, 32, width of the tagged PC

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
req_valid  in  1  EXE access accepted by the bus this cycle (addr_ok already qualified)
req_ready  out  1  queue can accept one more access
req_is_load  in  1  1 = load, 0 = store
req_size  in  2  00 byte, 01 half, 10 word, 11 dword (11 only legal when DATA_W=64)
req_sign  in  1  sign-extend the load result
req_offset  in  log2(DATA_W/8)  byte offset in the bus word
req_rd  in  5  destination register
req_pc  in  PC_W  instruction PC
data_ok  in  1  one response beat this cycle
rdata  in  DATA_W  response data
flush  in  1  exception/ertn/refetch flush from the MEM/WB boundary
out_valid  out  1  head access has completed
out_ready  in  1  WB accepts the head access
out_is_load  out  1  head is a load
out_rd  out  5  head rd (0 for stores)
out_wdata  out  DATA_W  aligned, extended load data (0 for stores)
out_pc  out  PC_W  head PC
resp_err  out  1  sticky flag for an unexpected data_ok

Behaviour:
- State:
  - Circular entry array; each entry holds {is_load, size, sign, offset, rd, pc, done, data}.
  - Pointers: wr_ptr, rsp_ptr (oldest entry not yet done), rd_ptr.
  - count (live entries); pend (live entries not done); drop_cnt, width log2(DEPTH)+1.
- Reset (async, resetn=0): all pointers, count, pend and drop_cnt = 0. All done bits = 0. out_valid=0, resp_err=0, req_ready=1. Data and metadata are not reset.
- req_ready = (count + drop_cnt) < DEPTH, registered-state only. There is no bypass: a retire and a full queue in the same cycle keep req_ready=0.
- Issue (req_valid & req_ready): write metadata at wr_ptr and clear its done bit; wr_ptr++, count++, pend++. If req_valid & ~req_ready, the request is ignored.
- data_ok handling, in priority order:
  1. If drop_cnt > 0: discard the beat; drop_cnt--.
  2. Else if pend > 0: write the extracted data into entry rsp_ptr; set done; rsp_ptr++, pend--.
  3. Else: ignore the beat and set resp_err=1. resp_err stays set until reset.
- Extraction of the lane, shifted by offset*8:
  - byte: rdata[8*off +: 8]
  - half: rdata[16*off[n:1] +: 16]
  - word: rdata[32*off[n:2] +: 32]
  - dword: the full word
  - Zero-extend to DATA_W, or sign-extend when sign=1.
  - Alignment is not checked (ALE is raised upstream).
- Latency: data_ok in cycle N gives out_valid in cycle N+1 at the earliest. Responses retire strictly in issue order.
- out_valid = count>0 & entry[rd_ptr].done & ~flush.
  - out_rd = is_load ? rd : 0. out_wdata = is_load ? data : 0.
  - Retire on out_valid & out_ready: rd_ptr++, count--.
- Flush (cycle F):
  - drop_cnt(next) = drop_cnt + pend + issue_F − (data_ok_F consumed by rule 2).
  - Then: count, pend = 0; all pointers = 0; all done bits cleared.
  - A request issued in cycle F is younger than the flushing instruction, so it is dropped.
  - out_valid is forced to 0 in cycle F, so no retire occurs in that cycle.
- Invariant: count + drop_cnt ≤ DEPTH. Pointers wrap modulo DEPTH.
- Simultaneous issue + data_ok + retire in one cycle are all legal. count/pend are updated by the net change.

Test Plan:
- Single access: issue LW (rd=5, pc=0x1c00_0000), data_ok at +3 with rdata=0x8000_00F0 → out_valid at +4, out_rd=5, out_wdata=0x8000_00F0, req_ready stays 1.
- Extraction, DATA_W=32:
  - rdata=0x1234_80FF, LB off=0 → 0xFFFF_FFFF
  - LBU off=1 → 0x0000_0080
  - LH off=2 → 0x0000_1234
  - LH off=0 → 0xFFFF_80FF
- Full: DEPTH=4; issue 4 loads with no data_ok → req_ready=0. Issue a 5th with req_valid=1 → ignored. Return 4 beats 0xA..0xD → in-order outputs 0xA..0xD; req_ready=1 the cycle after the first retire.
- Flush drop: 3 loads issued, 1 returned and done, flush with a 4th issued in the same cycle → drop_cnt=3, out_valid=0. The next 3 data_ok beats produce nothing. A new LW then returns 0x55 → out_wdata=0x55, resp_err=0.
- Store + backpressure: SW then LW; both responses returned; out_ready=0 for 5 cycles → SW held at the head with out_is_load=0, out_rd=0. Release → SW retires, then LW retires next cycle.
- Error + reset: data_ok with an empty queue → resp_err=1. Assert resetn=0 asynchronously mid-transfer → resp_err=0, out_valid=0, req_ready=1 immediately.
